// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer controller of an asynchronous FIFO: binary/Gray write pointer,
// registered full flag, conservative fill level and sticky overflow flag.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  w_clk_wr,
    input  logic                  w_rst_wr,
    input  logic                  w_inc_wr,
    input  logic [ADDR_WIDTH:0]   wq2_rptr_wr,
    output logic                  w_en_wr,
    output logic [ADDR_WIDTH-1:0] wr_addr_wr,
    output logic [ADDR_WIDTH:0]   wr_ptr_wr,
    output logic                  full_wr,
    output logic [ADDR_WIDTH:0]   wr_level_wr,
    output logic                  ovf_wr
);

    localparam int P = ADDR_WIDTH + 1;

    function automatic logic [P-1:0] bin2gray(input logic [P-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
        logic [P-1:0] b;
        b[P-1] = g[P-1];
        for (int i = P - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [P-1:0] wbin;
    logic [P-1:0] wbin_next;
    logic [P-1:0] wgray_next;
    logic [P-1:0] rbin_sync;
    logic         full_next;

    // Reset gates the enable so the memory never sees a write while held in reset.
    assign w_en_wr    = w_inc_wr & ~full_wr & w_rst_wr;
    assign wr_addr_wr = wbin[ADDR_WIDTH-1:0];

    assign wbin_next  = wbin + {{(P-1){1'b0}}, w_en_wr};
    assign wgray_next = bin2gray(wbin_next);
    assign rbin_sync  = gray2bin(wq2_rptr_wr);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_next  = (wgray_next == {~wq2_rptr_wr[P-1:P-2], wq2_rptr_wr[P-3:0]});

    always_ff @(posedge w_clk_wr or negedge w_rst_wr) begin
        if (!w_rst_wr) begin
            wbin        <= '0;
            wr_ptr_wr   <= '0;
            full_wr     <= 1'b0;
            wr_level_wr <= '0;
            ovf_wr      <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wr_ptr_wr   <= wgray_next;
            full_wr     <= full_next;
            wr_level_wr <= wbin_next - rbin_sync;
            if (w_inc_wr && full_wr) begin
                ovf_wr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a word-count model of the FIFO.
module tb_fifo_wr_ctrl;

    logic       w_clk_wr = 1'b0;
    logic       w_rst_wr = 1'b0;
    logic       w_inc_wr = 1'b0;
    logic [3:0] wq2_rptr_wr = 4'h0;
    logic       w_en_wr;
    logic [2:0] wr_addr_wr;
    logic [3:0] wr_ptr_wr;
    logic       full_wr;
    logic [3:0] wr_level_wr;
    logic       ovf_wr;

    int total = 0;
    int bad = 0;

    // Model state: words written and words read since reset.
    int  wc = 0;
    int  rc = 0;
    bit  mfull = 1'b0;
    bit  movf = 1'b0;

    fifo_wr_ctrl #(.ADDR_WIDTH(3)) dut (
        .w_clk_wr    (w_clk_wr),
        .w_rst_wr    (w_rst_wr),
        .w_inc_wr    (w_inc_wr),
        .wq2_rptr_wr (wq2_rptr_wr),
        .w_en_wr     (w_en_wr),
        .wr_addr_wr  (wr_addr_wr),
        .wr_ptr_wr   (wr_ptr_wr),
        .full_wr     (full_wr),
        .wr_level_wr (wr_level_wr),
        .ovf_wr      (ovf_wr)
    );

    always #5 w_clk_wr = ~w_clk_wr;

    typedef struct {
        bit         inc;
        logic [3:0] rq;
        bit         en;
        logic [2:0] addr;
        logic [3:0] ptr;
        bit         full;
        logic [3:0] lvl;
        bit         ovf;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [3:0] g(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_en"},   int'(w_en_wr), 0);
        chk({nm, "_addr"}, int'(wr_addr_wr), 0);
        chk({nm, "_ptr"},  int'(wr_ptr_wr), 0);
        chk({nm, "_full"}, int'(full_wr), 0);
        chk({nm, "_lvl"},  int'(wr_level_wr), 0);
        chk({nm, "_ovf"},  int'(ovf_wr), 0);
    endtask

    // Called on a falling edge; leaves the DUT out of reset at the next falling edge.
    task automatic do_reset();
        w_rst_wr = 1'b0;
        w_inc_wr = 1'b0;
        wq2_rptr_wr = 4'h0;
        #2;
        chk_all_zero("reset");
        @(negedge w_clk_wr);
        w_rst_wr = 1'b1;
        wc = 0; rc = 0; mfull = 1'b0; movf = 1'b0;
    endtask

    // One model-checked cycle; entered and left on a falling edge.
    task automatic mstep(input bit inc, input bit radv);
        if (radv && rc < wc) rc++;
        w_inc_wr = inc;
        wq2_rptr_wr = g(rc % 16);
        #1;
        chk("m_en",   int'(w_en_wr), int'(inc && !mfull));
        chk("m_addr", int'(wr_addr_wr), wc % 8);
        @(posedge w_clk_wr);
        if (inc && mfull) movf = 1'b1;
        if (inc && !mfull) wc++;
        mfull = ((wc - rc) == 8);
        @(negedge w_clk_wr);
        chk("m_ptr",  int'(wr_ptr_wr), int'(g(wc % 16)));
        chk("m_full", int'(full_wr), int'(mfull));
        chk("m_lvl",  int'(wr_level_wr), wc - rc);
        chk("m_ovf",  int'(ovf_wr), int'(movf));
    endtask

    initial begin
        // Fill, overflow, idle, drain release, refill, simultaneous advance while full.
        for (int i = 1; i <= 8; i++)
            tbl[i-1] = '{1'b1, 4'h0, 1'b1, 3'(i-1), g(i), (i == 8), 4'(i), 1'b0};
        tbl[8]  = '{1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 4'd8, 1'b1};
        tbl[9]  = '{1'b0, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 4'd8, 1'b1};
        tbl[10] = '{1'b0, 4'h1, 1'b0, 3'd0, 4'hC, 1'b0, 4'd7, 1'b1};
        tbl[11] = '{1'b1, 4'h1, 1'b1, 3'd0, 4'hD, 1'b1, 4'd8, 1'b1};
        tbl[12] = '{1'b1, 4'h3, 1'b0, 3'd1, 4'hD, 1'b0, 4'd7, 1'b1};

        @(negedge w_clk_wr);
        do_reset();

        for (int k = 0; k < 13; k++) begin
            w_inc_wr = tbl[k].inc;
            wq2_rptr_wr = tbl[k].rq;
            #1;
            chk($sformatf("v%0d_en", k),   int'(w_en_wr), int'(tbl[k].en));
            chk($sformatf("v%0d_addr", k), int'(wr_addr_wr), int'(tbl[k].addr));
            @(negedge w_clk_wr);
            chk($sformatf("v%0d_ptr", k),  int'(wr_ptr_wr), int'(tbl[k].ptr));
            chk($sformatf("v%0d_full", k), int'(full_wr), int'(tbl[k].full));
            chk($sformatf("v%0d_lvl", k),  int'(wr_level_wr), int'(tbl[k].lvl));
            chk($sformatf("v%0d_ovf", k),  int'(ovf_wr), int'(tbl[k].ovf));
        end

        // Asynchronous reset in the middle of a write burst, away from any clock edge.
        w_inc_wr = 1'b1;
        #2;
        w_rst_wr = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge w_clk_wr);
        w_rst_wr = 1'b1;
        wc = 0; rc = 0; mfull = 1'b0; movf = 1'b0;
        mstep(1'b1, 1'b0);

        // First overflow attempt coincides with the read pointer advancing.
        do_reset();
        for (int i = 0; i < 8; i++) mstep(1'b1, 1'b0);
        chk("sim_full_before", int'(full_wr), 1);
        mstep(1'b1, 1'b1);
        chk("sim_full_after", int'(full_wr), 0);
        chk("sim_ovf", int'(ovf_wr), 1);
        chk("sim_ptr", int'(wr_ptr_wr), 12);

        // Sixteen accepted writes with the read side trailing: pointers wrap, never full.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mstep(1'b1, (wc - rc) >= 3);
            chk("wrap_nofull", int'(full_wr), 0);
        end
        chk("wrap_ptr", int'(wr_ptr_wr), 0);
        chk("wrap_addr", int'(wr_addr_wr), 0);

        // Randomized traffic, with occasional write-heavy phases to reach full.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit heavy;
            heavy = ((i / 40) % 2) == 1;
            mstep($urandom_range(0, 3) != 0, heavy ? ($urandom_range(0, 3) == 0)
                                                   : ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
